// File: rtl/cpu_bus_master.sv
// Single-transfer initiator for the 8-bit CS_/OE_/WR_ register bus with programmable setup/strobe/hold/turn timing.
// Optional macro BUS_WRITE_READBACK_EN: every write is followed by a readback of the same address and a compare.
module cpu_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned TURN_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       CS_,
    output logic       OE_,
    output logic       WR_,
    output logic [7:0] Addr,
    inout  wire  [7:0] data_bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TURN
    } state_e;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] TURN_LD   = 4'(TURN_CYC - 1);
    localparam bit         TURN_EN   = (TURN_CYC != 0);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       rsp_valid_q;
    logic       ready_q, ready_d;
    logic       cs_n_q, cs_n_d;
    logic       oe_n_q, oe_n_d;
    logic       wr_n_q, wr_n_d;
    logic       drv_q, drv_d;
    logic       accept;
    logic       fin;
    logic       capture;
    logic       busy_d;
`ifdef BUS_WRITE_READBACK_EN
    logic       rb_q, rb_d;
    logic       err_q;
`endif

    assign accept = (state_q == ST_IDLE) && req;

    // Next-state and phase counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        fin     = 1'b0;
        capture = 1'b0;
`ifdef BUS_WRITE_READBACK_EN
        rb_d    = rb_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    wr_d    = req_wr;
`ifdef BUS_WRITE_READBACK_EN
                    rb_d    = 1'b0;
`endif
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    capture = !wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
`ifdef BUS_WRITE_READBACK_EN
                    // CS_ stays low: the readback SETUP follows the write HOLD directly
                    if (wr_q) begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                        wr_d    = 1'b0;
                        rb_d    = 1'b1;
                    end else begin
                        fin     = 1'b1;
                        state_d = TURN_EN ? ST_TURN : ST_IDLE;
                        cnt_d   = TURN_LD;
                    end
`else
                    fin     = 1'b1;
                    state_d = (!wr_q && TURN_EN) ? ST_TURN : ST_IDLE;
                    cnt_d   = TURN_LD;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so they can be registered
    always_comb begin
        busy_d  = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_n_d  = !busy_d;
        oe_n_d  = !((state_d == ST_STROBE) && !wr_d);
        wr_n_d  = !((state_d == ST_STROBE) && wr_d);
        drv_d   = busy_d && wr_d;
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            cs_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            drv_q       <= 1'b0;
`ifdef BUS_WRITE_READBACK_EN
            rb_q        <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            rsp_valid_q <= fin;
            ready_q     <= ready_d;
            cs_n_q      <= cs_n_d;
            oe_n_q      <= oe_n_d;
            wr_n_q      <= wr_n_d;
            drv_q       <= drv_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (capture) begin
                rdata_q <= data_bus;
            end
`ifdef BUS_WRITE_READBACK_EN
            rb_q <= rb_d;
            if (fin) begin
                err_q <= rb_q && (rdata_q != wdata_q);
            end
`endif
        end
    end

    assign data_bus  = drv_q ? wdata_q : 8'hzz;
    assign CS_       = cs_n_q;
    assign OE_       = oe_n_q;
    assign WR_       = wr_n_q;
    assign Addr      = addr_q;
    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
`ifdef BUS_WRITE_READBACK_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master with a 256-byte register model on the shared data bus.
// Honours BUS_WRITE_READBACK_EN (model then has bit 7 stuck at 0 on readout).
module tb_cpu_bus_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       CS_;
    logic       OE_;
    logic       WR_;
    logic [7:0] Addr;
    wire  [7:0] data_bus;

    cpu_bus_master dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .CS_       (CS_),
        .OE_       (OE_),
        .WR_       (WR_),
        .Addr      (Addr),
        .data_bus  (data_bus)
    );

    always #5 clk = ~clk;

`ifdef BUS_WRITE_READBACK_EN
    localparam logic [7:0]  RD_MASK = 8'h7F;
    localparam logic [31:0] W_CS    = 32'h0000_01FE;
    localparam logic [31:0] W_OE    = 32'h0000_00C0;
    localparam int          W_RSP   = 9;
    localparam bit          W_TURN  = 1'b1;
    localparam int          W_RUN   = 8;
`else
    localparam logic [7:0]  RD_MASK = 8'hFF;
    localparam logic [31:0] W_CS    = 32'h0000_001E;
    localparam logic [31:0] W_OE    = 32'h0000_0000;
    localparam int          W_RSP   = 5;
    localparam bit          W_TURN  = 1'b0;
    localparam int          W_RUN   = 4;
`endif

    // Register model: drives the bus only while CS_ and OE_ are both low
    logic [7:0] mem [256];
    assign data_bus = (!CS_ && !OE_) ? (mem[Addr] & RD_MASK) : 8'hzz;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[3] <= 8'h5A;
        end else if (!CS_ && !WR_) begin
            mem[Addr] <= data_bus;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit bus_free();
        return (data_bus === 8'hzz) || (data_bus === 8'h00);
    endfunction

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
    } vec_t;

    vec_t vecs [11];

    task automatic xfer(input int idx, input vec_t v);
        int          k;
        int          rsp_k;
        logic [31:0] cs_m;
        logic [31:0] wr_m;
        logic [31:0] oe_m;
        bit          turn;
        cs_m  = '0;
        wr_m  = '0;
        oe_m  = '0;
        rsp_k = 0;
        for (int t = 0; t < 40 && !req_ready; t++) @(negedge clk);
        check($sformatf("v%0d ready_before", idx), {31'b0, req_ready}, 32'd1);
        req       = 1'b1;
        req_wr    = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        req       = 1'b0;
        req_wr    = ~v.wr;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        k = 1;
        while (k < 30 && rsp_k == 0) begin
            if (!CS_) cs_m[k] = 1'b1;
            if (!WR_) wr_m[k] = 1'b1;
            if (!OE_) oe_m[k] = 1'b1;
            if (!OE_ && !WR_) check($sformatf("v%0d both_strobes", idx), 32'd1, 32'd0);
            if (!CS_) begin
                check($sformatf("v%0d addr k%0d", idx, k), {24'b0, Addr}, {24'b0, v.addr});
                if (v.wr && k <= 4)
                    check($sformatf("v%0d wdata k%0d", idx, k), {24'b0, data_bus}, {24'b0, v.wdata});
                else if (OE_)
                    check($sformatf("v%0d bus_free k%0d", idx, k), {31'b0, bus_free()}, 32'd1);
            end else begin
                check($sformatf("v%0d bus_idle k%0d", idx, k), {31'b0, bus_free()}, 32'd1);
            end
            if (rsp_valid) rsp_k = k;
            else begin
                @(negedge clk);
                k++;
            end
        end
        turn = v.wr ? W_TURN : 1'b1;
        check($sformatf("v%0d rsp_latency", idx), rsp_k, v.wr ? W_RSP : 5);
        check($sformatf("v%0d cs_cycles", idx), cs_m, v.wr ? W_CS : 32'h1E);
        check($sformatf("v%0d wr_cycles", idx), wr_m, v.wr ? 32'h0C : 32'h00);
        check($sformatf("v%0d oe_cycles", idx), oe_m, v.wr ? W_OE : 32'h0C);
        check($sformatf("v%0d rdata", idx), {24'b0, rsp_rdata}, {24'b0, v.rdata});
        check($sformatf("v%0d err", idx), {31'b0, rsp_err}, {31'b0, v.err});
        check($sformatf("v%0d ready_at_rsp", idx), {31'b0, req_ready}, {31'b0, !turn});
        @(negedge clk);
        check($sformatf("v%0d rsp_single", idx), {31'b0, rsp_valid}, 32'd0);
        check($sformatf("v%0d ready_after", idx), {31'b0, req_ready}, 32'd1);
        $display("xfer %0d: wr=%0d addr=%h wdata=%h rdata=%h err=%0d latency=%0d",
                 idx, v.wr, v.addr, v.wdata, rsp_rdata, rsp_err, rsp_k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int n_rsp;
        int runs;
        int run_len;
        int hits;

`ifdef BUS_WRITE_READBACK_EN
        vecs[0]  = '{1'b1, 8'h02, 8'hA5, 8'h25, 1'b1};
        vecs[1]  = '{1'b0, 8'h03, 8'hC3, 8'h5A, 1'b0};
        vecs[2]  = '{1'b1, 8'h01, 8'h11, 8'h11, 1'b0};
        vecs[3]  = '{1'b0, 8'h01, 8'hC3, 8'h11, 1'b0};
        vecs[4]  = '{1'b1, 8'hFF, 8'h3C, 8'h3C, 1'b0};
        vecs[5]  = '{1'b0, 8'hFF, 8'hC3, 8'h3C, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 8'hC3, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 8'hFF, 8'h7F, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 8'hC3, 8'h7F, 1'b0};
        vecs[9]  = '{1'b1, 8'h10, 8'h80, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 8'h10, 8'hC3, 8'h00, 1'b0};
`else
        vecs[0]  = '{1'b1, 8'h02, 8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h03, 8'hC3, 8'h5A, 1'b0};
        vecs[2]  = '{1'b1, 8'h01, 8'h11, 8'h5A, 1'b0};
        vecs[3]  = '{1'b0, 8'h01, 8'hC3, 8'h11, 1'b0};
        vecs[4]  = '{1'b1, 8'hFF, 8'h3C, 8'h11, 1'b0};
        vecs[5]  = '{1'b0, 8'hFF, 8'hC3, 8'h3C, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 8'hC3, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 8'hC3, 8'hFF, 1'b0};
        vecs[9]  = '{1'b1, 8'h10, 8'h80, 8'hFF, 1'b0};
        vecs[10] = '{1'b0, 8'h10, 8'hC3, 8'h80, 1'b0};
`endif

        rst       = 1'b1;
        req       = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and 10 idle cycles
        hits = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) hits++;
            if (c == 0 || c == 9) begin
                check("idle CS_", {31'b0, CS_}, 32'd1);
                check("idle OE_", {31'b0, OE_}, 32'd1);
                check("idle WR_", {31'b0, WR_}, 32'd1);
                check("idle Addr", {24'b0, Addr}, 32'd0);
                check("idle bus", {31'b0, bus_free()}, 32'd1);
                check("idle ready", {31'b0, req_ready}, 32'd1);
                check("idle rdata", {24'b0, rsp_rdata}, 32'd0);
                check("idle err", {31'b0, rsp_err}, 32'd0);
            end
        end
        check("idle rsp_valid_count", hits, 0);
        $display("idle: 10 cycles, rsp_valid pulses=%0d", hits);

        for (int i = 0; i < 11; i++) xfer(i, vecs[i]);

        // req held high, alternating write(0x01,0x11)/read(0x01)
        n_acc   = 0;
        n_rsp   = 0;
        runs    = 0;
        run_len = 0;
        for (int c = 0; c < 80 && (n_rsp < 4 || !CS_); c++) begin
            if (n_acc < 4) begin
                req = 1'b1;
                if (req_ready) begin
                    req_wr    = (n_acc % 2 == 0);
                    req_addr  = 8'h01;
                    req_wdata = 8'h11;
                end else begin
                    req_wr    = ~req_wr;
                    req_addr  = 8'hEE;
                    req_wdata = 8'h99;
                end
            end else begin
                req = 1'b0;
            end
            if (!CS_) begin
                run_len++;
                check("b2b addr", {24'b0, Addr}, 32'h01);
                check("b2b not_ready", {31'b0, req_ready}, 32'd0);
            end else if (run_len > 0) begin
                check($sformatf("b2b run%0d len", runs), run_len, (runs % 2 == 0) ? W_RUN : 4);
                run_len = 0;
                runs++;
            end
            if (rsp_valid) begin
                if (n_rsp % 2 == 1) begin
                    check("b2b read rdata", {24'b0, rsp_rdata}, 32'h11);
                    check("b2b read err", {31'b0, rsp_err}, 32'd0);
                end
                $display("b2b rsp %0d: rdata=%h err=%0d", n_rsp, rsp_rdata, rsp_err);
                n_rsp++;
            end
            if (req && req_ready) n_acc++;
            @(negedge clk);
        end
        req = 1'b0;
        check("b2b accepts", n_acc, 4);
        check("b2b responses", n_rsp, 4);
        check("b2b cs_runs", runs, 4);

        // Reset during the second STROBE cycle of a write
        for (int t = 0; t < 40 && !req_ready; t++) @(negedge clk);
        req       = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 8'h05;
        req_wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst pre WR_", {31'b0, WR_}, 32'd0);
        check("rst pre CS_", {31'b0, CS_}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst CS_", {31'b0, CS_}, 32'd1);
        check("rst WR_", {31'b0, WR_}, 32'd1);
        check("rst OE_", {31'b0, OE_}, 32'd1);
        check("rst bus", {31'b0, bus_free()}, 32'd1);
        check("rst ready", {31'b0, req_ready}, 32'd1);
        check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst  = 1'b0;
        hits = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid || !CS_) hits++;
        end
        check("rst no_rsp_after", hits, 0);
        $display("reset mid-strobe: quiet cycles checked, activity=%0d", hits);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
